// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - LSU widths, load-type codes, FSM states; LSU_MISALIGN_CHECK_EN adds the alignment helper
package lsu_mem_ctrl_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int MEM_MASK_WIDTH = ISA_WIDTH / 8;
    localparam int LD_TYPE_WIDTH  = 3;

    localparam logic [LD_TYPE_WIDTH-1:0] LD_LB  = 3'd0;
    localparam logic [LD_TYPE_WIDTH-1:0] LD_LH  = 3'd1;
    localparam logic [LD_TYPE_WIDTH-1:0] LD_LW  = 3'd2;
    localparam logic [LD_TYPE_WIDTH-1:0] LD_LBU = 3'd4;
    localparam logic [LD_TYPE_WIDTH-1:0] LD_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

`ifdef LSU_MISALIGN_CHECK_EN
    // Stores are sized by their mask, loads by their type.
    function automatic logic misaligned(input logic [1:0]                off,
                                        input logic                      is_store,
                                        input logic [MEM_MASK_WIDTH-1:0] mask,
                                        input logic [LD_TYPE_WIDTH-1:0]  ld_type);
        logic half;
        logic word;
        if (is_store) begin
            half = (mask == MEM_MASK_WIDTH'(3));
            word = (mask == '1);
        end else begin
            half = (ld_type == LD_LH) || (ld_type == LD_LHU);
            word = (ld_type == LD_LW);
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction
`endif

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - EXU request, data-memory bus and WBU result signals of the LSU
// LSU_MISALIGN_CHECK_EN adds lsu_err.
interface lsu_mem_ctrl_if
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DW = ISA_WIDTH,
    parameter int MW = MEM_MASK_WIDTH
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [DW-1:0]            mem_addr;
    logic [DW-1:0]            mem_w;
    logic [MW-1:0]            mem_mask;
    logic                     mem_r_en;
    logic                     mem_w_en;
    logic [LD_TYPE_WIDTH-1:0] ld_type;

    logic                     bus_req_valid;
    logic                     bus_req_ready;
    logic                     bus_req_we;
    logic [DW-1:0]            bus_req_addr;
    logic [DW-1:0]            bus_req_wdata;
    logic [MW-1:0]            bus_req_wstrb;
    logic                     bus_resp_valid;
    logic [DW-1:0]            bus_resp_rdata;

    logic                     out_valid;
    logic                     out_ready;
    logic [DW-1:0]            ld_data;
`ifdef LSU_MISALIGN_CHECK_EN
    logic                     lsu_err;
`endif

    modport slave (
        input  in_valid, mem_addr, mem_w, mem_mask, mem_r_en, mem_w_en, ld_type,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata, out_ready,
        output in_ready, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        output out_valid, ld_data
`ifdef LSU_MISALIGN_CHECK_EN
        , output lsu_err
`endif
    );

    modport master (
        output in_valid, mem_addr, mem_w, mem_mask, mem_r_en, mem_w_en, ld_type,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata, out_ready,
        input  in_ready, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        input  out_valid, ld_data
`ifdef LSU_MISALIGN_CHECK_EN
        , input lsu_err
`endif
    );

endinterface

// File: rtl/lsu_mem_ctrl_load_fmt.sv
// rtl/lsu_mem_ctrl_load_fmt.sv - combinational byte-lane alignment and sign/zero extension of load data
module lsu_load_fmt
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DW = ISA_WIDTH
) (
    input  logic [DW-1:0]            rdata,
    input  logic [1:0]               off,
    input  logic [LD_TYPE_WIDTH-1:0] ld_type,
    output logic [DW-1:0]            fmt_data
);

    logic [DW-1:0] sh;

    always_comb begin
        sh       = rdata >> {off, 3'b000};
        // Reserved codes fall through to the byte zero-extend.
        fmt_data = {{(DW-8){1'b0}}, sh[7:0]};
        case (ld_type)
            LD_LB:   fmt_data = {{(DW-8){sh[7]}}, sh[7:0]};
            LD_LH:   fmt_data = {{(DW-16){sh[15]}}, sh[15:0]};
            LD_LHU:  fmt_data = {{(DW-16){1'b0}}, sh[15:0]};
            LD_LW:   fmt_data = sh;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit: one aligned bus access per request, result handed to WBU
// LSU_MISALIGN_CHECK_EN adds lsu_err and short-circuits misaligned accesses.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DW = ISA_WIDTH,
    parameter int MW = MEM_MASK_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_ctrl_if.slave  lsu_io
);

    lsu_state_e               state_q;
    logic                     in_ready_q;
    logic                     req_valid_q;
    logic                     req_we_q;
    logic [DW-1:0]            req_addr_q;
    logic [DW-1:0]            req_wdata_q;
    logic [MW-1:0]            req_wstrb_q;
    logic                     out_valid_q;
    logic [DW-1:0]            ld_data_q;
    logic [1:0]               off_q;
    logic [LD_TYPE_WIDTH-1:0] ld_type_q;
    logic [DW-1:0]            fmt_data_d;
    logic                     mis_d;
    logic                     any_en_d;

    assign any_en_d = lsu_io.mem_r_en | lsu_io.mem_w_en;

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;

    assign mis_d          = misaligned(lsu_io.mem_addr[1:0], lsu_io.mem_w_en,
                                       lsu_io.mem_mask, lsu_io.ld_type);
    assign lsu_io.lsu_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && lsu_io.in_valid) begin
            err_q <= any_en_d & mis_d;
        end else if (state_q == ST_DONE && lsu_io.out_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    assign mis_d = 1'b0;
`endif

    lsu_load_fmt #(.DW(DW)) u_load_fmt (
        .rdata    (lsu_io.bus_resp_rdata),
        .off      (off_q),
        .ld_type  (ld_type_q),
        .fmt_data (fmt_data_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            out_valid_q <= 1'b0;
            ld_data_q   <= '0;
            off_q       <= 2'b00;
            ld_type_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lsu_io.in_valid) begin
                        in_ready_q  <= 1'b0;
                        // Store wins when both enables are set.
                        req_we_q    <= lsu_io.mem_w_en;
                        req_addr_q  <= {lsu_io.mem_addr[DW-1:2], 2'b00};
                        req_wdata_q <= lsu_io.mem_w << {lsu_io.mem_addr[1:0], 3'b000};
                        req_wstrb_q <= lsu_io.mem_mask << lsu_io.mem_addr[1:0];
                        off_q       <= lsu_io.mem_addr[1:0];
                        ld_type_q   <= lsu_io.ld_type;
                        if (!any_en_d || mis_d) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            ld_data_q   <= '0;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (lsu_io.bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Store completion is the write ack; it carries no load data.
                    if (lsu_io.bus_resp_valid) begin
                        ld_data_q   <= req_we_q ? '0 : fmt_data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (lsu_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lsu_io.in_ready      = in_ready_q;
    assign lsu_io.bus_req_valid = req_valid_q;
    assign lsu_io.bus_req_we    = req_we_q;
    assign lsu_io.bus_req_addr  = req_addr_q;
    assign lsu_io.bus_req_wdata = req_wdata_q;
    assign lsu_io.bus_req_wstrb = req_wstrb_q;
    assign lsu_io.out_valid     = out_valid_q;
    assign lsu_io.ld_data       = ld_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl; LSU_MISALIGN_CHECK_EN selects the lsu_err checks
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    lsu_mem_ctrl_if ifc ();

    lsu_mem_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .lsu_io (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned lane_scale(input int off);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < off; k++) p = p * 256;
        return p;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off, input logic [2:0] t);
        longint unsigned sh;
        longint unsigned b;
        longint unsigned h;
        sh = {32'b0, rdata} / lane_scale(off);
        b  = sh % 256;
        h  = sh % 65536;
        if (t == LD_LB)  return (b >= 128)   ? 32'(b + 64'hFFFF_FF00) : 32'(b);
        if (t == LD_LH)  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
        if (t == LD_LHU) return 32'(h);
        if (t == LD_LW)  return 32'(sh);
        return 32'(b);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] w, input int off);
        return 32'(({32'b0, w} * lane_scale(off)) % 64'h1_0000_0000);
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [3:0] mask, input int off);
        int unsigned v;
        v = int'(mask) * (1 << off);
        return 4'(v % 16);
    endfunction

    function automatic logic ref_mis(input int off, input logic w_en, input logic [3:0] mask, input logic [2:0] t);
        int size;
        if (w_en) size = (mask == 4'b1111) ? 4 : (mask == 4'b0011) ? 2 : 1;
        else      size = (t == LD_LW) ? 4 : (t == LD_LH || t == LD_LHU) ? 2 : 1;
        return (off % size) != 0;
    endfunction

    task automatic do_access(input logic [31:0] addr, input logic [31:0] w, input logic [3:0] mask,
                             input logic r_en, input logic w_en, input logic [2:0] ldt,
                             input logic [31:0] rdata, input int req_wait, input int resp_wait,
                             input int out_wait);
        int          off;
        logic        direct;
        logic        mis;
        logic [31:0] exp_ld;
        int          lat;
        off = int'(addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (r_en || w_en) && ref_mis(off, w_en, mask, ldt);
`else
        mis = 1'b0;
`endif
        direct = !(r_en || w_en) || mis;
        exp_ld = (direct || w_en) ? 32'd0 : ref_load(rdata, off, ldt);

        @(negedge clk);
        chk("in_ready_idle", 32'(ifc.in_ready), 32'd1);
        ifc.mem_addr = addr; ifc.mem_w = w; ifc.mem_mask = mask;
        ifc.mem_r_en = r_en; ifc.mem_w_en = w_en; ifc.ld_type = ldt;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        ifc.in_valid = 1'b0;
        ifc.mem_addr = $urandom; ifc.mem_w = $urandom; ifc.mem_mask = 4'($urandom);
        ifc.mem_r_en = 1'($urandom); ifc.mem_w_en = 1'($urandom); ifc.ld_type = 3'($urandom);
        chk("in_ready_busy", 32'(ifc.in_ready), 32'd0);
        if (!direct) begin
            for (int i = 0; i <= req_wait; i++) begin
                chk("req_valid", 32'(ifc.bus_req_valid), 32'd1);
                chk("req_addr", ifc.bus_req_addr, addr - 32'(off));
                chk("req_we", 32'(ifc.bus_req_we), 32'(w_en));
                chk("req_wdata", ifc.bus_req_wdata, ref_wdata(w, off));
                chk("req_wstrb", 32'(ifc.bus_req_wstrb), 32'(ref_wstrb(mask, off)));
                chk("in_ready_req", 32'(ifc.in_ready), 32'd0);
                if (i == req_wait) ifc.bus_req_ready = 1'b1;
                @(negedge clk);
                lat++;
            end
            ifc.bus_req_ready = 1'b0;
            for (int i = 0; i <= resp_wait; i++) begin
                chk("req_single_beat", 32'(ifc.bus_req_valid), 32'd0);
                chk("out_valid_early", 32'(ifc.out_valid), 32'd0);
                if (i == resp_wait) begin
                    ifc.bus_resp_valid = 1'b1;
                    ifc.bus_resp_rdata = rdata;
                end
                @(negedge clk);
                lat++;
            end
            ifc.bus_resp_valid = 1'b0;
            ifc.bus_resp_rdata = $urandom;
        end
        chk("out_valid", 32'(ifc.out_valid), 32'd1);
        chk("latency", 32'(lat), direct ? 32'd1 : 32'(3 + req_wait + resp_wait));
        chk("ld_data", ifc.ld_data, exp_ld);
        chk("no_req_in_done", 32'(ifc.bus_req_valid), 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lsu_err", 32'(ifc.lsu_err), 32'(mis));
`endif
        for (int i = 0; i < out_wait; i++) begin
            @(negedge clk);
            chk("out_valid_held", 32'(ifc.out_valid), 32'd1);
            chk("ld_data_held", ifc.ld_data, exp_ld);
            chk("in_ready_done", 32'(ifc.in_ready), 32'd0);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk("out_valid_drop", 32'(ifc.out_valid), 32'd0);
        chk("in_ready_back", 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] masks [3];
        n_cmp  = 0;
        n_fail = 0;
        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111;
        rst = 1'b0;
        ifc.in_valid = 1'b0; ifc.mem_addr = '0; ifc.mem_w = '0; ifc.mem_mask = '0;
        ifc.mem_r_en = 1'b0; ifc.mem_w_en = 1'b0; ifc.ld_type = '0;
        ifc.bus_req_ready = 1'b0; ifc.bus_resp_valid = 1'b0; ifc.bus_resp_rdata = '0;
        ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_req_valid", 32'(ifc.bus_req_valid), 32'd0);
        chk("rst_req_we", 32'(ifc.bus_req_we), 32'd0);
        chk("rst_req_addr", ifc.bus_req_addr, 32'd0);
        chk("rst_req_wdata", ifc.bus_req_wdata, 32'd0);
        chk("rst_req_wstrb", 32'(ifc.bus_req_wstrb), 32'd0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_ld_data", ifc.ld_data, 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("rst_lsu_err", 32'(ifc.lsu_err), 32'd0);
`endif
        rst = 1'b1;

        do_access(32'h8000_0004, 32'h0, 4'hF, 1'b1, 1'b0, LD_LW, 32'hDEAD_BEEF, 0, 0, 0);
        do_access(32'h8000_0003, 32'h0, 4'h1, 1'b1, 1'b0, LD_LB, 32'h80FF_0000, 0, 0, 0);
        do_access(32'h8000_0003, 32'h0, 4'h1, 1'b1, 1'b0, LD_LBU, 32'h80FF_0000, 0, 0, 0);
        do_access(32'h8000_0002, 32'h0, 4'h3, 1'b1, 1'b0, LD_LHU, 32'h80FF_0000, 0, 0, 0);
        do_access(32'h8000_0002, 32'h0, 4'h3, 1'b1, 1'b0, LD_LH, 32'h80FF_0000, 1, 0, 1);
        do_access(32'h8000_0001, 32'hAB, 4'h1, 1'b0, 1'b1, LD_LB, 32'h1234_5678, 0, 0, 0);
        do_access(32'h0000_0100, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, LD_LW, 32'h0BAD_F00D, 5, 3, 2);
        do_access(32'h0000_0101, 32'h55, 4'h1, 1'b1, 1'b1, LD_LW, 32'hFFFF_FFFF, 0, 1, 0);
        do_access(32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b0, LD_LW, 32'hFFFF_FFFF, 0, 0, 1);
        do_access(32'h0000_0041, 32'h0, 4'h1, 1'b1, 1'b0, 3'd3, 32'h0000_F700, 0, 0, 0);
        do_access(32'h8000_0002, 32'h0, 4'hF, 1'b1, 1'b0, LD_LW, 32'h1122_3344, 0, 0, 0);
        do_access(32'h8000_0003, 32'h1234, 4'h3, 1'b0, 1'b1, LD_LB, 32'h0, 0, 0, 0);

        // Reset while the bus response is still outstanding.
        @(negedge clk);
        ifc.mem_addr = 32'h8000_0008; ifc.mem_mask = 4'hF; ifc.mem_r_en = 1'b1;
        ifc.mem_w_en = 1'b0; ifc.ld_type = LD_LW; ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.bus_req_ready = 1'b1;
        @(negedge clk);
        ifc.bus_req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_wait_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_wait_req_valid", 32'(ifc.bus_req_valid), 32'd0);
        ifc.bus_resp_valid = 1'b1;
        ifc.bus_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ifc.bus_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stale_out_valid", 32'(ifc.out_valid), 32'd0);
            chk("stale_in_ready", 32'(ifc.in_ready), 32'd1);
            @(negedge clk);
        end

        for (int n = 0; n < 60; n++) begin
            logic [1:0] en;
            en = 2'($urandom);
            do_access($urandom, $urandom, masks[$urandom_range(0, 2)], en[0], en[1],
                      3'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
